// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory slave.
// No timing of its own; the helpers are pure combinational functions.
// No handshakes live here; flow control belongs to the modules that import it.
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // limit is the byte size of the array; 33 bits so a full 4 GiB space still fits
    function automatic logic addr_err(input logic [31:0] addr, input logic [32:0] limit);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with four byte-lane write enables and a registered read port.
// Write lands on the enabling edge; read data appears after the edge that has re_i high.
// No handshake; the read register holds its value until the next read.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           CLK,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [BE_W-1:0]                be_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic [DATA_W-1:0]              rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[idx_i] <= (mem_q[idx_i] & ~be_mask(be_i)) | (wdata_i & be_mask(be_i));
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store data-memory slave: one outstanding request, fixed wait states, then a response.
// Response valid WAIT_STATES+1 cycles after accept; one transaction per WAIT_STATES+3 cycles at best.
// req_ready only in IDLE; the response holds stable for as long as rsp_ready stays low.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              wr_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              accept, commit, cap_err;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready = (state_q == IDLE) && !RESET;
    assign accept    = req_valid && req_ready;
    assign cap_err   = addr_err(addr_q, LIMIT);

    // The accept cycle itself is spent in WAIT, so the counter starts at WAIT_STATES
    // and RESP is reached WAIT_STATES+1 edges after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                    err_d   = cap_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .CLK    (CLK),
        .we_i   (commit && wr_q && !cap_err),
        .re_i   (commit && !wr_q && !cap_err),
        .idx_i  (addr_q[AW+1:2]),
        .be_i   (be_q),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at three wait-state settings (2, 0, 15) with a response scoreboard.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int          ws_tab [3] = '{2, 0, 15};
    logic [31:0] model [3][256];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WSG = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
        dmem_responder #(
            .DEPTH_WORDS(256),
            .WAIT_STATES(WSG)
        ) u_dut (
            .CLK      (clk),
            .RESET    (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_write(req_write[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold>0 keeps rsp_ready low for that many cycles of RESP
    // while driving a conflicting request that must be ignored.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        exp_t        e;
        int          k;
        logic [31:0] w;
        e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        e.rdata = (wr || e.err) ? 32'h0 : model[d][addr[9:2]];
        if (wr && !e.err) begin
            w = model[d][addr[9:2]];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            end
            model[d][addr[9:2]] = w;
        end
        sb.push_back(e);
        chk("idle_req_ready", {31'b0, req_ready[d]}, 32'h1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = (hold == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hFFFF_FFFF;
        req_wdata[d] = $urandom;
        k = 0;
        while (rsp_valid[d] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(ws_tab[d] + 1));
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata[d], e.rdata);
        chk("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'b1;
                req_addr[d]  = 32'h10;
                req_wdata[d] = 32'h0BAD_0BAD;
                req_be[d]    = 4'hF;
            end
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid[d]}, 32'h1);
            chk("hold_rdata", rsp_rdata[d], e.rdata);
            chk("hold_err", {31'b0, rsp_err[d]}, {31'b0, e.err});
            chk("hold_req_ready", {31'b0, req_ready[d]}, 32'h0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("done_valid", {31'b0, rsp_valid[d]}, 32'h0);
        chk("done_rdata", rsp_rdata[d], 32'h0);
        chk("done_req_ready", {31'b0, req_ready[d]}, 32'h1);
    endtask

    initial begin
        int acc [$];
        int k;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
            req_be[d]    = 4'h0;
            rsp_ready[d] = 1'b1;
            for (int i = 0; i < 256; i++) model[d][i] = 32'h0;
        end

        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready[0]}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err[0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'b0, req_ready[0]}, 32'h1);

        // store then load
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        // byte lanes
        txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h24, 32'h5555_5555, 4'b0000, 0);
        txn(0, 1'b0, 32'h24, 32'h0, 4'hF, 0);
        // errors
        txn(0, 1'b1, 32'h0, 32'hA5A5_5A5A, 4'hF, 0);
        txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, 0);
        txn(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0);
        // backpressure, then confirm the ignored store did not land
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // reset abort during WAIT
        txn(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'h0000_0055;
        req_be[0]    = 4'hF;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        chk("abort_req_ready", {31'b0, req_ready[0]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_held_req_ready", {31'b0, req_ready[0]}, 32'h0);
        chk("abort_held_rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0);

        // timing extremes
        txn(1, 1'b1, 32'h4, 32'h0BEE_F00D, 4'hF, 0);
        txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 0);
        txn(2, 1'b1, 32'h8, 32'h7777_8888, 4'b1100, 0);
        txn(2, 1'b0, 32'h8, 32'h0, 4'h0, 0);

        // back-to-back with req_valid held high
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        rsp_ready[0] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (req_ready[0]) acc.push_back(t);
            if (rsp_valid[0]) chk("b2b_rdata", rsp_rdata[0], model[0][4]);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        chk("b2b_accepts", 32'(acc.size()), 32'd4);
        if (acc.size() >= 3) begin
            chk("b2b_gap0", 32'(acc[1] - acc[0]), 32'(ws_tab[0] + 3));
            chk("b2b_gap1", 32'(acc[2] - acc[1]), 32'(ws_tab[0] + 3));
        end
        k = 0;
        while (req_ready[0] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_drain", {31'b0, req_ready[0]}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
